// File: rtl/filter_arbiter_pkg.sv
// rtl/filter_arbiter_pkg.sv - shared widths, pair-word field offsets and FSM encoding for filter_arbiter
package filter_arbiter_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int PARTICLE_ID_WIDTH = 20;
  localparam int NUM_FILTER        = 8;
  localparam int FILTER_SEL_WIDTH  = 3;
  localparam int PAIR_WIDTH        = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH;

  // Pair word layout, MSB to LSB: {ref_id, neighbor_id, r2, dz, dy, dx}
  localparam int DX_LSB  = 0;
  localparam int DY_LSB  = DX_LSB + DATA_WIDTH;
  localparam int DZ_LSB  = DY_LSB + DATA_WIDTH;
  localparam int R2_LSB  = DZ_LSB + DATA_WIDTH;
  localparam int NB_LSB  = R2_LSB + DATA_WIDTH;
  localparam int REF_LSB = NB_LSB + PARTICLE_ID_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/filter_arbiter_rr_priority_select.sv
// rtl/filter_arbiter_rr_priority_select.sv - combinational round-robin pick: first eligible index at or after ptr
module rr_priority_select #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_idx_o,
  output logic         any_grant_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;

  always_comb begin
    // rot[k] is eligibility of index (ptr + k) mod N
    dbl         = {eligible_i, eligible_i} >> ptr_i;
    rot         = dbl[N-1:0];
    sum         = '0;
    any_grant_o = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        sum         = {1'b0, ptr_i} + (W+1)'(k);
        any_grant_o = 1'b1;
      end
    end
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    grant_idx_o = sum[W-1:0];
    grant_o     = any_grant_o ? (N'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/filter_arbiter.sv
// rtl/filter_arbiter.sv - round-robin reader sharing one force pipeline across the filter bank
// Optional FILTER_ARBITER_STATS_EN adds per-filter grant counters and a stall-cycle counter.
module filter_arbiter
  import filter_arbiter_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               input_done,
  input  logic                               pipeline_stall,
  input  logic [NUM_FILTER-1:0]              particle_pair_available,
  input  logic [NUM_FILTER*PAIR_WIDTH-1:0]   filter_pair_data,
  output logic [NUM_FILTER-1:0]              sel,
  output logic [PARTICLE_ID_WIDTH-1:0]       ref_particle_id_out,
  output logic [PARTICLE_ID_WIDTH-1:0]       neighbor_particle_id_out,
  output logic [DATA_WIDTH-1:0]              r2_out,
  output logic [DATA_WIDTH-1:0]              dx_out,
  output logic [DATA_WIDTH-1:0]              dy_out,
  output logic [DATA_WIDTH-1:0]              dz_out,
  output logic                               pair_valid,
  output logic                               arbiter_done,
`ifdef FILTER_ARBITER_STATS_EN
  output logic [NUM_FILTER*16-1:0]           grant_count,
  output logic [15:0]                        stall_cycles,
`endif
  output logic                               arbiter_busy
);

  state_e                      state_q;
  logic [FILTER_SEL_WIDTH-1:0] ptr_q, ptr_d, gidx_q, grant_idx;
  logic [NUM_FILTER-1:0]       cooldown_q, eligible, grant;
  logic                        any_grant, issue_ok, fire, drain_idle;
  logic                        inflight_q, done_pend_q, drain_cnt_q;
  logic [PAIR_WIDTH-1:0]       words [NUM_FILTER];
  logic [PAIR_WIDTH-1:0]       rd_word;

  for (genvar g = 0; g < NUM_FILTER; g++) begin : g_words
    assign words[g] = filter_pair_data[g*PAIR_WIDTH +: PAIR_WIDTH];
  end

  // Cooldown hides the granted filter for one cycle while its empty flag catches up
  assign eligible = particle_pair_available & ~cooldown_q;

  rr_priority_select #(
    .N (NUM_FILTER),
    .W (FILTER_SEL_WIDTH)
  ) u_rr (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign arbiter_busy = (state_q == ST_ARB) || (state_q == ST_DRAIN);
  assign issue_ok     = arbiter_busy && enable && !pipeline_stall;
  assign fire         = issue_ok && any_grant;
  assign sel          = fire ? grant : '0;
  assign ptr_d        = (grant_idx == FILTER_SEL_WIDTH'(NUM_FILTER-1)) ? '0 : grant_idx + 1'b1;
  assign drain_idle   = (particle_pair_available == '0) && !inflight_q;
  assign rd_word      = words[gidx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                  <= ST_IDLE;
      ptr_q                    <= '0;
      cooldown_q               <= '0;
      inflight_q               <= 1'b0;
      gidx_q                   <= '0;
      done_pend_q              <= 1'b0;
      drain_cnt_q              <= 1'b0;
      pair_valid               <= 1'b0;
      arbiter_done             <= 1'b0;
      ref_particle_id_out      <= '0;
      neighbor_particle_id_out <= '0;
      r2_out                   <= '0;
      dx_out                   <= '0;
      dy_out                   <= '0;
      dz_out                   <= '0;
    end else begin
      cooldown_q   <= sel;
      inflight_q   <= fire;
      gidx_q       <= grant_idx;
      pair_valid   <= inflight_q;
      arbiter_done <= 1'b0;
      if (fire) begin
        ptr_q <= ptr_d;
      end
      if (inflight_q) begin
        ref_particle_id_out      <= rd_word[REF_LSB +: PARTICLE_ID_WIDTH];
        neighbor_particle_id_out <= rd_word[NB_LSB +: PARTICLE_ID_WIDTH];
        r2_out                   <= rd_word[R2_LSB +: DATA_WIDTH];
        dz_out                   <= rd_word[DZ_LSB +: DATA_WIDTH];
        dy_out                   <= rd_word[DY_LSB +: DATA_WIDTH];
        dx_out                   <= rd_word[DX_LSB +: DATA_WIDTH];
      end
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q     <= ST_ARB;
            done_pend_q <= input_done;
            drain_cnt_q <= 1'b0;
          end
        end
        ST_ARB: begin
          if (!enable) begin
            if (!inflight_q) state_q <= ST_IDLE;
          end else if (input_done || done_pend_q) begin
            state_q     <= ST_DRAIN;
            done_pend_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!enable) begin
            if (!inflight_q) state_q <= ST_IDLE;
          end else begin
            // Two consecutive idle cycles absorb the one-cycle lag of the empty flags
            drain_cnt_q <= drain_idle;
            if (drain_idle && drain_cnt_q) begin
              state_q      <= ST_DONE;
              arbiter_done <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FILTER_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE && enable)) begin
      grant_count  <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_FILTER; i++) begin
        if (sel[i] && grant_count[i*16 +: 16] != 16'hFFFF) begin
          grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
        end
      end
      if (arbiter_busy && enable && pipeline_stall && (particle_pair_available != '0)
          && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/filter_arbiter.md
Name: filter_arbiter

Overview:
- Shares one force pipeline between NUM_FILTER filter-logic instances in a filter bank.
- Each filter exposes a non-empty flag (pair available) and accepts a one-hot read strobe (sel).
- The arbiter picks one filter per cycle in round-robin order, issues its read, and muxes the returned pair into a registered output stage with a valid flag.
- A small state machine handles enable, end-of-input drain, and a done pulse for the cell/step controller.

Parameters:
- DATA_WIDTH, 32, float width of r2/dx/dy/dz.
- PARTICLE_ID_WIDTH, 20, particle ID width.
- NUM_FILTER, 8, number of filters arbitrated (2..16).
- FILTER_SEL_WIDTH, 3, log2(NUM_FILTER).
- PAIR_WIDTH, 2*PARTICLE_ID_WIDTH+4*DATA_WIDTH, width of one pair word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  start arbitration (level)
- input_done  in  1  pulse: input generator has sent its last pair
- pipeline_stall  in  1  force pipeline cannot take new issues
- particle_pair_available  in  NUM_FILTER  per-filter non-empty flag
- filter_pair_data  in  NUM_FILTER*PAIR_WIDTH  filter i at [i*PAIR_WIDTH +: PAIR_WIDTH]; fields MSB-LSB {ref_id, neighbor_id, r2, dz, dy, dx}
- sel  out  NUM_FILTER  one-hot read strobe, at most one bit set
- ref_particle_id_out  out  PARTICLE_ID_WIDTH  granted pair ref ID
- neighbor_particle_id_out  out  PARTICLE_ID_WIDTH  granted pair neighbor ID
- r2_out, dx_out, dy_out, dz_out  out  DATA_WIDTH each  granted pair values
- pair_valid  out  1  output pair valid this cycle
- arbiter_done  out  1  one-cycle pulse after drain completes
- arbiter_busy  out  1  high in ARB or DRAIN

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer 0; in-flight pipe cleared; cooldown mask 0. Reset mid-operation discards in-flight pairs and never emits pair_valid for them.
- States:
  - IDLE -> ARB when enable=1.
  - ARB -> DRAIN on input_done=1.
  - DRAIN -> DONE when: particle_pair_available==0, no reads in flight, and both held for 2 consecutive cycles (covers 1-cycle empty-flag lag).
  - DONE: arbiter_done=1 for one cycle, then IDLE.
  - enable=0 in ARB or DRAIN -> IDLE after in-flight reads complete; no new sel.
- Eligible set = particle_pair_available & ~cooldown_mask. Issue only in ARB/DRAIN with pipeline_stall=0.
- Grant: the first eligible index at or after the RR pointer, wrapping modulo NUM_FILTER. The pointer moves to grant+1 (wrapping) only on a grant.
- sel is driven combinationally from the registered eligible/pointer state. It is high for exactly one cycle per grant, i.e. one buffer read.
- Cooldown: the filter granted in cycle N is ineligible in cycle N+1, because its empty flag updates one cycle late. A single active filter is therefore read at most every other cycle.
- Latency: sel in cycle N -> buffer data valid N+1 -> captured from the registered grant index -> pair_valid in cycle N+2. Throughput is 1 pair/cycle when 2 or more filters are available.
- Output fields are sliced from the selected pair word without modification. The output holds its last value when pair_valid=0.
- pipeline_stall only blocks new issues. Up to 2 already in-flight pairs still emerge, and downstream must absorb them.
- input_done in the same cycle as enable rising: go IDLE->ARB, and record input_done so DRAIN is entered next cycle.
- input_done while IDLE is ignored.

Optional Feature:
- FILTER_ARBITER_STATS_EN: adds output grant_count (NUM_FILTER*16 bits, one saturating counter per filter) and output stall_cycles (16 bits: cycles with available!=0 but issue blocked by pipeline_stall). Counters clear on rst and on IDLE->ARB.
- Without the macro: no extra ports or logic.

Decomposition:
- Shared package: PAIR_WIDTH, field offsets for ref_id/neighbor_id/r2/dz/dy/dx, state encoding (IDLE, ARB, DRAIN, DONE).
- One sub-module: rr_priority_select (eligible vector + pointer -> one-hot grant, grant index, any_grant). It is purely combinational and reusable by the future pipeline-level arbiter.

Test Plan:
- NUM_FILTER=8, all available continuously, pointer 0 -> sel order 0,1,...,7,0. pair_valid every cycle from cycle 3. Each output pair equals the granted filter's data word from cycle N+1.
- Only filter 5 available -> sel=8'h20 every other cycle, never back-to-back. pair_valid alternates 1,0.
- Filters 2 and 6 available, pipeline_stall raised for 4 cycles -> no sel during the stall. The 2 in-flight pairs still appear. Round-robin resumes from the saved pointer.
- input_done with 3 pairs still buffered -> 3 pair_valid cycles. arbiter_done pulses once, 2 cycles after the last read with available==0. State returns to IDLE.
- rst asserted 1 cycle after a sel -> next cycle all outputs 0, no pair_valid for the discarded read, state IDLE.
- STATS_EN: 10 grants to filter 1, 3 blocked-stall cycles -> grant_count[1]=10, stall_cycles=3.
